// File: rtl/mux_rr_arbiter_if.sv
// Request/grant/data bundle between eight serial requesters and the
// round-robin mux arbiter.
interface mux_rr_arbiter_if;
    logic [7:0] req;
    logic [7:0] data_in;
    logic [7:0] grant;
    logic [2:0] sel;
    logic       active;
    logic       data_out;

    modport master (
        output req,
        output data_in,
        input  grant,
        input  sel,
        input  active,
        input  data_out
    );

    modport slave (
        input  req,
        input  data_in,
        output grant,
        output sel,
        output active,
        output data_out
    );
endinterface

// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter sharing an 8:1 bit-select mux among eight requesters.
// Define MUX_ARB_TIMEOUT_EN to bound each grant to MAX_HOLD cycles.
module mux_8x1 (
    input  logic [7:0] in,
    input  logic [2:0] sel,
    output logic       out
);
    assign out = in[sel];
endmodule

module mux_rr_arbiter #(
    parameter int unsigned MAX_HOLD = 16
) (
    input logic             clk,
    input logic             rst,
    mux_rr_arbiter_if.slave bus
);
    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] GRANT = 1'b1;

    if (MAX_HOLD < 2 || MAX_HOLD > 255) begin : g_bad_max_hold
        $error("MAX_HOLD must be in 2..255");
    end

    logic [0:0] state;
    logic [2:0] ptr;
    logic       timeout;
    logic [7:0] mask;
    logic [2:0] idx;
    logic [2:0] cand;
    logic       found;
    logic       hold;
    logic       take;
    logic [2:0] next_idx;
    logic       mux_out;

`ifdef MUX_ARB_TIMEOUT_EN
    logic [7:0] hold_cnt;

    assign timeout = (state == GRANT) && (hold_cnt == 8'(MAX_HOLD));
`else
    assign timeout = 1'b0;
`endif

    // A timed-out holder is masked so the others get a turn first.
    always_comb begin
        mask  = bus.req;
        idx   = '0;
        cand  = '0;
        found = 1'b0;
        if (timeout)
            mask[bus.sel] = 1'b0;
        for (int i = 0; i < 8; i++) begin
            idx = ptr + 3'(i);
            if (!found && mask[idx]) begin
                cand  = idx;
                found = 1'b1;
            end
        end
    end

    assign hold = (state == GRANT) && bus.req[bus.sel] && !timeout;

    // Lone timed-out requester is re-granted to itself.
    assign take     = found || (timeout && bus.req[bus.sel]);
    assign next_idx = found ? cand : bus.sel;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            ptr        <= '0;
            bus.grant  <= '0;
            bus.sel    <= '0;
            bus.active <= 1'b0;
        end else if (!hold) begin
            if (take) begin
                state      <= GRANT;
                ptr        <= next_idx + 3'd1;
                bus.grant  <= 8'b1 << next_idx;
                bus.sel    <= next_idx;
                bus.active <= 1'b1;
            end else begin
                state      <= IDLE;
                bus.grant  <= '0;
                bus.sel    <= '0;
                bus.active <= 1'b0;
            end
        end
    end

`ifdef MUX_ARB_TIMEOUT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            hold_cnt <= '0;
        else if (hold)
            hold_cnt <= hold_cnt + 8'd1;
        else if (take)
            hold_cnt <= 8'd1;
        else
            hold_cnt <= '0;
    end
`endif

    mux_8x1 u_mux (
        .in  (bus.data_in),
        .sel (bus.sel),
        .out (mux_out)
    );

    assign bus.data_out = mux_out & bus.active;
endmodule
